// File: rtl/gate_2x2_sched_if.sv
// Job/result handshake bundle for the 2x2 gate scheduler.
// master = job producer / result consumer, slave = the scheduler.
interface gate_2x2_sched_if #(
  parameter int IN_BITS  = 37,
  parameter int OUT_BITS = 38
);
  localparam int RES_BITS = OUT_BITS + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [8*IN_BITS-1:0]  gate;
  logic [4*IN_BITS-1:0]  amp;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*RES_BITS-1:0] result;

  modport master (
    output in_valid, gate, amp, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, gate, amp, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/gate_2x2_sched.sv
// 2x2 complex gate applied to an amplitude pair, time-multiplexed over one
// shared external complex multiplier: four products, one per cycle, summed
// into two wrap-around accumulators.
module gate_2x2_sched #(
  parameter int IN_BITS  = 37,
  parameter int OUT_BITS = 38
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gate_2x2_sched_if.slave            io,
  output logic [IN_BITS-1:0]         mul_x_re,
  output logic [IN_BITS-1:0]         mul_x_im,
  output logic [IN_BITS-1:0]         mul_y_re,
  output logic [IN_BITS-1:0]         mul_y_im,
  input  logic signed [OUT_BITS-1:0] mul_out_re,
  input  logic signed [OUT_BITS-1:0] mul_out_im,
  output logic                       busy
);
  localparam int RES_BITS = OUT_BITS + 1;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

  state_t                      state;
  logic [8*IN_BITS-1:0]        g_q;
  logic [4*IN_BITS-1:0]        a_q;
  logic signed [RES_BITS-1:0]  acc0_re, acc0_im, acc1_re, acc1_im;
  logic                        rdy_q, vld_q, busy_q;

  // one-bit sign extension of a product to accumulator width
  function automatic logic signed [RES_BITS-1:0] sx(input logic signed [OUT_BITS-1:0] p);
    return {p[OUT_BITS-1], p};
  endfunction

  // operand select: gate element on x, amplitude on y, zero outside MULn
  int  gi, ai;
  logic op_en;
  always_comb begin
    gi    = 0;
    ai    = 0;
    op_en = 1'b0;
    case (state)
      MUL0:    begin gi = 0; ai = 0; op_en = 1'b1; end
      MUL1:    begin gi = 1; ai = 1; op_en = 1'b1; end
      MUL2:    begin gi = 2; ai = 0; op_en = 1'b1; end
      MUL3:    begin gi = 3; ai = 1; op_en = 1'b1; end
      default: begin gi = 0; ai = 0; op_en = 1'b0; end
    endcase
    mul_x_re = '0;
    mul_x_im = '0;
    mul_y_re = '0;
    mul_y_im = '0;
    if (op_en) begin
      mul_x_re = g_q[(2*gi)*IN_BITS   +: IN_BITS];
      mul_x_im = g_q[(2*gi+1)*IN_BITS +: IN_BITS];
      mul_y_re = a_q[(2*ai)*IN_BITS   +: IN_BITS];
      mul_y_im = a_q[(2*ai+1)*IN_BITS +: IN_BITS];
    end
  end

  // scheduler FSM with registered handshake/status outputs and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      g_q     <= '0;
      a_q     <= '0;
      acc0_re <= '0;
      acc0_im <= '0;
      acc1_re <= '0;
      acc1_im <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          g_q    <= io.gate;
          a_q    <= io.amp;
          rdy_q  <= 1'b0;
          busy_q <= 1'b1;
          state  <= MUL0;
        end
        MUL0: begin
          acc0_re <= sx(mul_out_re);
          acc0_im <= sx(mul_out_im);
          state   <= MUL1;
        end
        MUL1: begin
          acc0_re <= acc0_re + sx(mul_out_re);
          acc0_im <= acc0_im + sx(mul_out_im);
          state   <= MUL2;
        end
        MUL2: begin
          acc1_re <= sx(mul_out_re);
          acc1_im <= sx(mul_out_im);
          state   <= MUL3;
        end
        MUL3: begin
          acc1_re <= acc1_re + sx(mul_out_re);
          acc1_im <= acc1_im + sx(mul_out_im);
          vld_q   <= 1'b1;
          state   <= DONE;
        end
        DONE: if (io.out_ready) begin
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          rdy_q  <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          rdy_q  <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = rdy_q;
  assign io.out_valid = vld_q;
  assign io.result    = {acc1_im, acc1_re, acc0_im, acc0_re};
  assign busy         = busy_q;
endmodule

// File: tb/tb_gate_2x2_sched.sv
// Directed bench for gate_2x2_sched: multiplier stub keyed on the gate
// element it sees, scoreboard queue of hand-computed results, negedge monitor.
module tb_gate_2x2_sched;
  localparam int IB = 37;
  localparam int OB = 38;
  localparam int RB = OB + 1;
  localparam logic signed [RB-1:0] ACC_MAX = 39'h3F_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [IB-1:0] mul_x_re, mul_x_im, mul_y_re, mul_y_im;
  logic signed [OB-1:0] mul_out_re, mul_out_im;
  logic busy;

  gate_2x2_sched_if #(.IN_BITS(IB), .OUT_BITS(OB)) io ();

  gate_2x2_sched #(.IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .mul_x_re(mul_x_re), .mul_x_im(mul_x_im),
    .mul_y_re(mul_y_re), .mul_y_im(mul_y_im),
    .mul_out_re(mul_out_re), .mul_out_im(mul_out_im),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4*RB-1:0] exp_q[$];

  // current job: gate/amp elements and the product the stub returns per step
  logic [IB-1:0] ure[4], uim[4], are[2], aim[2];
  logic signed [OB-1:0] prod_re[4], prod_im[4];

  // stub: identify the step by which gate element sits on mul_x_re
  always_comb begin
    mul_out_re = '0;
    mul_out_im = '0;
    for (int k = 0; k < 4; k++)
      if (mul_x_re == ure[k]) begin
        mul_out_re = prod_re[k];
        mul_out_im = prod_im[k];
      end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*RB-1:0] res(input longint b0r, input longint b0i,
                                          input longint b1r, input longint b1i);
    return {RB'(b1i), RB'(b1r), RB'(b0i), RB'(b0r)};
  endfunction

  function automatic logic [255:0] ops_now();
    return 256'({mul_x_re, mul_x_im, mul_y_re, mul_y_im});
  endfunction

  function automatic logic [255:0] ops_exp(input int s);
    return 256'({ure[s], uim[s], are[s%2], aim[s%2]});
  endfunction

  task automatic set_u(input int base);
    for (int k = 0; k < 4; k++) begin
      ure[k] = IB'(base + 17*k + 3);
      uim[k] = IB'(-(base + 5*k + 1));
    end
    for (int k = 0; k < 2; k++) begin
      are[k] = IB'(base * 3 + 11*k + 2);
      aim[k] = IB'(-(base * 2 + 7*k + 9));
    end
  endtask

  task automatic set_p(input longint r0, input longint r1, input longint r2, input longint r3,
                       input longint i0, input longint i1, input longint i2, input longint i3);
    prod_re[0] = OB'(r0); prod_re[1] = OB'(r1); prod_re[2] = OB'(r2); prod_re[3] = OB'(r3);
    prod_im[0] = OB'(i0); prod_im[1] = OB'(i1); prod_im[2] = OB'(i2); prod_im[3] = OB'(i3);
  endtask

  // present a job and return one edge after acceptance (state MUL0);
  // gate/amp are scrambled and in_valid left high to prove they are ignored
  task automatic start_job(input logic [4*RB-1:0] exp);
    int t = 0;
    while (!io.in_ready && t < 20) begin tick(); t++; end
    chk("in_ready_before_job", 256'(io.in_ready), 256'(1'b1));
    for (int k = 0; k < 4; k++) begin
      io.gate[(2*k)*IB   +: IB] = ure[k];
      io.gate[(2*k+1)*IB +: IB] = uim[k];
    end
    for (int k = 0; k < 2; k++) begin
      io.amp[(2*k)*IB   +: IB] = are[k];
      io.amp[(2*k+1)*IB +: IB] = aim[k];
    end
    io.in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    io.gate = ~io.gate;
    io.amp  = ~io.amp;
  endtask

  task automatic run_job(input logic [4*RB-1:0] exp, input int hold, input bit preload);
    start_job(exp);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) tick();
      if (preload && s == 1) begin
        force dut.acc0_re = ACC_MAX;
        #1;
        release dut.acc0_re;
      end
      chk("operands_mul", ops_now(), ops_exp(s));
      chk("out_valid_during_mul", 256'(io.out_valid), 256'(1'b0));
      chk("in_ready_during_mul", 256'(io.in_ready), 256'(1'b0));
      chk("busy_during_mul", 256'(busy), 256'(1'b1));
    end
    io.in_valid = 1'b0;
    // accepting edge counts as the first of the five edges to out_valid
    tick();
    chk("out_valid_latency", 256'(io.out_valid), 256'(1'b1));
    chk("operands_done_zero", ops_now(), 256'(0));
    chk("in_ready_done", 256'(io.in_ready), 256'(1'b0));
    repeat (hold) begin
      tick();
      chk("out_valid_held", 256'(io.out_valid), 256'(1'b1));
      chk("in_ready_held", 256'(io.in_ready), 256'(1'b0));
    end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("out_valid_after_take", 256'(io.out_valid), 256'(1'b0));
    chk("in_ready_after_take", 256'(io.in_ready), 256'(1'b1));
    chk("busy_idle", 256'(busy), 256'(1'b0));
    chk("operands_idle_zero", ops_now(), 256'(0));
  endtask

  // scoreboard monitor: compare every cycle result is presented, pop on take
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && io.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got result %0h with no job pending at %0t",
                   io.result, $time);
        end else begin
          chk("result", 256'(io.result), 256'(exp_q[0]));
          if (io.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.gate      = '0;
    io.amp       = '0;
    set_u(100);
    set_p(0, 0, 0, 0, 0, 0, 0, 0);

    // reset asserted between edges takes effect at once
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 256'(io.in_ready), 256'(1'b1));
    chk("rst_out_valid", 256'(io.out_valid), 256'(1'b0));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_result", 256'(io.result), 256'(0));
    chk("rst_operands", ops_now(), 256'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // accumulation with hand-computed sums, immediate take
    set_u(100);
    set_p(5, 7, -3, 2, 1, -1, 4, 4);
    run_job(res(12, 0, -1, 8), 0, 1'b0);

    // backpressure for 10 cycles, then back-to-back second job
    set_u(300);
    run_job(res(12, 0, -1, 8), 10, 1'b0);
    set_u(500);
    set_p(10, 20, 30, 40, -5, -6, 7, 8);
    run_job(res(30, -11, 70, 15), 0, 1'b0);

    // two maximum products: largest reachable sum, no wrap
    set_u(700);
    set_p(64'sh1F_FFFF_FFFF, 64'sh1F_FFFF_FFFF, 0, 0, 0, 0, 0, 0);
    run_job(res(64'sh3F_FFFF_FFFE, 0, 0, 0), 0, 1'b0);

    // accumulator preloaded at +max plus +1 wraps to the most negative value
    set_u(900);
    set_p(3, 1, 0, 0, 0, 0, 0, 0);
    run_job(res(-64'sh40_0000_0000, 0, 0, 0), 0, 1'b1);

    // reset during MUL2 discards the job
    set_u(1100);
    set_p(9, 9, 9, 9, 9, 9, 9, 9);
    start_job(res(36, 36, 36, 36));
    io.in_valid = 1'b0;
    tick();
    tick();
    chk("mid_state_mul2_ops", ops_now(), ops_exp(2));
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_in_ready", 256'(io.in_ready), 256'(1'b1));
    chk("midrst_busy", 256'(busy), 256'(1'b0));
    chk("midrst_out_valid", 256'(io.out_valid), 256'(1'b0));
    chk("midrst_result", 256'(io.result), 256'(0));
    chk("midrst_operands", ops_now(), 256'(0));
    #2 rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("no_out_valid_after_rst", 256'(io.out_valid), 256'(1'b0));
    end

    // next job completes normally
    set_u(1300);
    set_p(-100, -1, 50, 50, 0, 0, -9, 9);
    run_job(res(-101, 0, 100, 0), 0, 1'b0);

    tick();
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
